// File: rtl/hoop_round_ctrl_pkg.sv
// Shared definitions for the hoop game front end and its neighbours.
//   state_t        : round state encoding (IDLE / RUN / DONE)
//   DEF_*          : default timing constants and the score width that is
//                    also used by the leaderboard
//   cnt_width()    : counter width helper that never returns 0
package hoop_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_CLK_HZ       = 50000000;
   localparam int DEF_GAME_SECS    = 10;
   localparam int DEF_DEBOUNCE_CYC = 500000;
   localparam int DEF_SCORE_W      = 8;

   // $clog2(1) is 0, which would give a zero-width counter
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hoop_round_ctrl_if.sv
// Player/display side signal bundle of hoop_round_ctrl.
//   start, in_switch : raw asynchronous inputs (button, hoop switch)
//   score, time_left : live round status
//   game_active      : high while a round runs
//   game_over        : one-cycle strobe at round end, final_score valid with it
//   basket           : one-cycle strobe per counted basket
// master = environment that drives the raw inputs, slave = the controller.
interface hoop_round_ctrl_if
   import hoop_pkg::*;
#(
   parameter int SCORE_W = DEF_SCORE_W
);
   logic               start;
   logic               in_switch;
   logic [SCORE_W-1:0] score;
   logic [7:0]         time_left;
   logic               game_active;
   logic               game_over;
   logic [SCORE_W-1:0] final_score;
   logic               basket;

   modport master (
      output start, in_switch,
      input  score, time_left, game_active, game_over, final_score, basket
   );

   modport slave (
      input  start, in_switch,
      output score, time_left, game_active, game_over, final_score, basket
   );
endinterface

// File: rtl/hoop_round_ctrl_debounce.sv
// hoop_debounce: 2-flop synchroniser, hold-time debouncer and rising-edge
// strobe for one raw asynchronous input.
//   clock, reset : system clock, synchronous active-low reset
//   raw          : asynchronous bouncy input
//   rise         : one-cycle strobe when the debounced level goes 0->1
module hoop_debounce
   import hoop_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic rise
);
   localparam int CNT_W = cnt_width(DEBOUNCE_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic [1:0]       sync_reg;
   logic             level_reg;
   logic             rise_reg;
   logic [CNT_W-1:0] cnt_reg;

   // The counter only advances on consecutive cycles that disagree with the
   // accepted level; any agreeing cycle restarts the hold window.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync_reg  <= '0;
         level_reg <= 1'b0;
         rise_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         sync_reg <= {sync_reg[0], raw};
         rise_reg <= 1'b0;
         if (sync_reg[1] == level_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            level_reg <= sync_reg[1];
            rise_reg  <= sync_reg[1];
         end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   assign rise = rise_reg;

endmodule

// File: rtl/hoop_round_ctrl.sv
// hoop_round_ctrl: game-round front end. Conditions the hoop switch, runs the
// countdown and counts baskets while a round is live.
//   clock, reset : system clock, synchronous active-low reset
//   bus (slave)  : start/in_switch in; score, time_left, game_active,
//                  game_over, final_score, basket out
module hoop_round_ctrl
   import hoop_pkg::*;
#(
   parameter int CLK_HZ       = DEF_CLK_HZ,
   parameter int GAME_SECS    = DEF_GAME_SECS,
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int SCORE_W      = DEF_SCORE_W
) (
   input  logic             clock,
   input  logic             reset,
   hoop_round_ctrl_if.slave bus
);
   localparam int TICK_W = cnt_width(CLK_HZ);
   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(CLK_HZ - 1);
   localparam logic [7:0]         SECS_INIT = 8'(GAME_SECS);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   state_t             state_reg, state_next;
   logic [1:0]         start_sync_reg;
   logic               start_prev_reg;
   logic               start_rise;
   logic               shot;
   logic [TICK_W-1:0]  tick_reg, tick_next;
   logic [7:0]         time_left_reg, time_left_next;
   logic [SCORE_W-1:0] score_reg, score_next;
   logic [SCORE_W-1:0] final_score_reg, final_score_next;
   logic               game_over_reg, game_over_next;
   logic               basket_reg, basket_next;

   hoop_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_switch (
      .clock (clock),
      .reset (reset),
      .raw   (bus.in_switch),
      .rise  (shot)
   );

   assign start_rise = start_sync_reg[1] & ~start_prev_reg;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg       <= IDLE;
         start_sync_reg  <= '0;
         start_prev_reg  <= 1'b0;
         tick_reg        <= '0;
         time_left_reg   <= SECS_INIT;
         score_reg       <= '0;
         final_score_reg <= '0;
         game_over_reg   <= 1'b0;
         basket_reg      <= 1'b0;
      end else begin
         state_reg       <= state_next;
         start_sync_reg  <= {start_sync_reg[0], bus.start};
         start_prev_reg  <= start_sync_reg[1];
         tick_reg        <= tick_next;
         time_left_reg   <= time_left_next;
         score_reg       <= score_next;
         final_score_reg <= final_score_next;
         game_over_reg   <= game_over_next;
         basket_reg      <= basket_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      tick_next        = tick_reg;
      time_left_next   = time_left_reg;
      score_next       = score_reg;
      final_score_next = final_score_reg;
      game_over_next   = 1'b0;
      basket_next      = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            if (start_rise) begin
               state_next     = RUN;
               tick_next      = '0;
               time_left_next = SECS_INIT;
               score_next     = '0;
            end
         end
         RUN: begin
            if (shot) begin
               basket_next = 1'b1;
               if (score_reg != SCORE_MAX) begin
                  score_next = score_reg + 1'b1;
               end
            end
            if (tick_reg == TICK_LAST) begin
               tick_next = '0;
               if (time_left_reg != 8'd0) begin
                  time_left_next = time_left_reg - 8'd1;
               end
               if (time_left_reg <= 8'd1) begin
                  state_next       = DONE;
                  game_over_next   = 1'b1;
                  // score_next already includes a shot landing on this cycle
                  final_score_next = score_next;
               end
            end else begin
               tick_next = tick_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.score       = score_reg;
   assign bus.time_left   = time_left_reg;
   assign bus.game_active = (state_reg == RUN);
   assign bus.game_over   = game_over_reg;
   assign bus.final_score = final_score_reg;
   assign bus.basket      = basket_reg;

endmodule

// File: tb/tb_hoop_round_ctrl.sv
// Directed and randomized checks of hoop_round_ctrl (CLK_HZ=10, GAME_SECS=3,
// DEBOUNCE_CYC=4); a second instance with a long round and short debounce
// drives the score into saturation.
module tb_hoop_round_ctrl;
   localparam int DB = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   g = 0;

   int   bask_a = 0, bask_b = 0, go_cnt = 0, go_cyc = 0, ga_cyc = 0;
   logic ga_prev = 1'b0;
   logic [7:0] tl_prev = 8'd3;
   int   bask_q[$];
   int   tl_cyc_q[$];
   int   tl_val_q[$];

   hoop_round_ctrl_if #(.SCORE_W(8)) bus_a ();
   hoop_round_ctrl_if #(.SCORE_W(8)) bus_b ();

   hoop_round_ctrl #(.CLK_HZ(10), .GAME_SECS(3), .DEBOUNCE_CYC(DB), .SCORE_W(8)) dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (bus_a)
   );

   hoop_round_ctrl #(.CLK_HZ(10), .GAME_SECS(255), .DEBOUNCE_CYC(2), .SCORE_W(8)) dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (bus_b)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // event monitor, sampled on the falling edge
   always @(negedge clock) begin
      if (bus_a.basket === 1'b1) begin
         bask_a++;
         bask_q.push_back(cyc);
      end
      if (bus_a.game_over === 1'b1) begin
         go_cnt++;
         go_cyc = cyc;
      end
      if (bus_a.game_active === 1'b1 && ga_prev !== 1'b1) ga_cyc = cyc;
      ga_prev = bus_a.game_active;
      if (bus_a.time_left !== tl_prev) begin
         tl_cyc_q.push_back(cyc);
         tl_val_q.push_back(int'(bus_a.time_left));
      end
      tl_prev = bus_a.time_left;
      if (bus_b.basket === 1'b1) bask_b++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) step(1);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic start_a();
      int c0;
      bus_a.start = 1'b1;
      c0 = cyc;
      step(1);
      bus_a.start = 1'b0;
      while (bus_a.game_active !== 1'b1 && (cyc - c0) < 12) step(1);
      check("start_latency", cyc - c0, 3);
      g = cyc;
   endtask

   task automatic wait_go_a();
      int c0;
      c0 = cyc;
      while (bus_a.game_over !== 1'b1 && (cyc - c0) < 40) step(1);
      check("round_end_seen", bus_a.game_over, 1);
   endtask

   initial begin
      int b0, r1, r2;
      bus_a.start = 1'b0; bus_a.in_switch = 1'b0;
      bus_b.start = 1'b0; bus_b.in_switch = 1'b0;

      // 1: reset values, switch activity in IDLE is ignored
      step(2);
      check("rst_score", bus_a.score, 0);
      check("rst_time_left", bus_a.time_left, 3);
      check("rst_game_active", bus_a.game_active, 0);
      check("rst_game_over", bus_a.game_over, 0);
      check("rst_final_score", bus_a.final_score, 0);
      check("rst_basket", bus_a.basket, 0);
      reset = 1'b1;
      step(2);
      for (int i = 0; i < 4; i++) begin
         bus_a.in_switch = ~bus_a.in_switch;
         step(8);
      end
      check("idle_score", bus_a.score, 0);
      check("idle_baskets", bask_a, 0);

      // 2 + 4: two clean shots, countdown, full round end
      b0 = bask_a;
      start_a();
      bask_q.delete(); tl_cyc_q.delete(); tl_val_q.delete();
      r1 = cyc; bus_a.in_switch = 1'b1; step(10);
      bus_a.in_switch = 1'b0; step(10);
      r2 = cyc; bus_a.in_switch = 1'b1; step(10);
      check("end_game_over", bus_a.game_over, 1);
      check("end_time_left", bus_a.time_left, 0);
      check("end_final_score", bus_a.final_score, 2);
      check("end_score", bus_a.score, 2);
      check("end_game_active", bus_a.game_active, 0);
      step(1);
      check("go_one_cycle", bus_a.game_over, 0);
      check("go_after_30", go_cyc - ga_cyc, 30);
      check("basket1_latency", qget(bask_q, 0) - r1, 7);
      check("basket2_latency", qget(bask_q, 1) - r2, 7);
      check("tl_step1_cyc", qget(tl_cyc_q, 0) - g, 10);
      check("tl_step1_val", qget(tl_val_q, 0), 2);
      check("tl_step2_cyc", qget(tl_cyc_q, 1) - g, 20);
      check("tl_step2_val", qget(tl_val_q, 1), 1);
      check("tl_step3_cyc", qget(tl_cyc_q, 2) - g, 30);
      check("tl_step3_val", qget(tl_val_q, 2), 0);
      bus_a.in_switch = 1'b0; step(8);
      bus_a.in_switch = 1'b1; step(8);
      bus_a.in_switch = 1'b0; step(8);
      check("done_baskets", bask_a - b0, 2);
      check("done_score_hold", bus_a.score, 2);
      check("done_time_hold", bus_a.time_left, 0);

      // 3: bounce gives one basket, 3-cycle glitch gives none
      b0 = bask_a;
      start_a();
      check("new_round_score0", bus_a.score, 0);
      check("new_round_time", bus_a.time_left, 3);
      for (int i = 0; i < 4; i++) begin
         bus_a.in_switch = (i % 2 == 0);
         step(1);
      end
      bus_a.in_switch = 1'b1; step(8);
      bus_a.in_switch = 1'b0; step(8);
      bus_a.in_switch = 1'b1; step(3);
      bus_a.in_switch = 1'b0; step(5);
      wait_go_a();
      check("bounce_final", bus_a.final_score, 1);
      step(1);
      check("bounce_baskets", bask_a - b0, 1);

      // 5: shot landing on the final wrap is counted
      step(5);
      start_a();
      wait_cyc(g + 2);
      bus_a.in_switch = 1'b1; step(6);
      bus_a.in_switch = 1'b0;
      wait_cyc(g + 23);
      bus_a.in_switch = 1'b1;
      wait_cyc(g + 30);
      check("wrap_game_over", bus_a.game_over, 1);
      check("wrap_basket", bus_a.basket, 1);
      check("wrap_final_score", bus_a.final_score, 2);
      check("wrap_score", bus_a.score, 2);
      step(1);
      bus_a.in_switch = 1'b0; step(10);

      // 6: reset mid-round
      start_a();
      bus_a.in_switch = 1'b1; step(6);
      bus_a.in_switch = 1'b0;
      wait_cyc(g + 12);
      check("pre_rst_time", bus_a.time_left, 2);
      check("pre_rst_score", bus_a.score, 1);
      b0 = go_cnt;
      reset = 1'b0; step(1);
      check("midrst_active", bus_a.game_active, 0);
      check("midrst_score", bus_a.score, 0);
      check("midrst_time", bus_a.time_left, 3);
      check("midrst_final", bus_a.final_score, 0);
      check("midrst_go", bus_a.game_over, 0);
      reset = 1'b1; step(40);
      check("midrst_no_go", go_cnt - b0, 0);
      check("midrst_idle", bus_a.game_active, 0);

      // random rounds against a segment-level model: a level is accepted only
      // if held for at least DB cycles, every accepted 0->1 is one basket
      for (int rnd = 0; rnd < 6; rnd++) begin
         int total, len, val, acc, exp_shots, bb;
         bb = bask_a;
         start_a();
         total = 0; val = 1; acc = 0; exp_shots = 0;
         while (total < 20) begin
            len = int'($urandom_range(6, 1));
            if (total + len > 20) len = 20 - total;
            bus_a.in_switch = (val == 1);
            step(len);
            if (len >= DB && val != acc) begin
               acc = val;
               if (val == 1) exp_shots++;
            end
            total += len;
            val = 1 - val;
         end
         bus_a.in_switch = 1'b0;
         wait_go_a();
         check("rand_final_score", bus_a.final_score, exp_shots);
         step(1);
         bus_a.in_switch = 1'b1; step(6);
         bus_a.in_switch = 1'b0; step(10);
         check("rand_score_hold", bus_a.score, exp_shots);
         check("rand_baskets", bask_a - bb, exp_shots);
      end

      // saturation on the long-round instance
      bus_b.start = 1'b1; step(1);
      bus_b.start = 1'b0;
      begin
         int n = 0;
         while (bus_b.game_active !== 1'b1 && n < 12) begin
            step(1);
            n++;
         end
      end
      check("sat_active", bus_b.game_active, 1);
      for (int i = 0; i < 255; i++) begin
         bus_b.in_switch = 1'b1; step(3);
         bus_b.in_switch = 1'b0; step(3);
      end
      step(6);
      check("sat_score_255", bus_b.score, 255);
      check("sat_baskets_255", bask_b, 255);
      bus_b.in_switch = 1'b1; step(3);
      bus_b.in_switch = 1'b0; step(8);
      check("sat_score_hold", bus_b.score, 255);
      check("sat_basket_pulse", bask_b, 256);
      check("sat_still_active", bus_b.game_active, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hoop_round_ctrl.md
Name: hoop_round_ctrl

Overview:
- Game-round front end for the hoop game: conditions the raw hoop switch, runs the countdown, and counts baskets only while a round is live.
- Sits directly upstream of the leaderboard and seven-segment/VGA display path.
- Supplies the live score, the seconds remaining, and a one-cycle commit strobe carrying the final score when a round ends.

Parameters:
- CLK_HZ, 50000000, clock cycles per game second.
- GAME_SECS, 10, round length in seconds (1..255).
- DEBOUNCE_CYC, 500000, cycles the synchronised switch must hold a new level before it is accepted (>=2).
- SCORE_W, 8, score width.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous reset, active-low.
- start  in  1  start-round request, level, asynchronous (push button).
- in_switch  in  1  raw hoop switch, asynchronous, bouncy; 1 = ball present.
- score  out  SCORE_W  baskets this round.
- time_left  out  8  seconds remaining.
- game_active  out  1  high while state RUN.
- game_over  out  1  single-cycle strobe on RUN->DONE.
- final_score  out  SCORE_W  score latched at round end; valid with and after game_over.
- basket  out  1  single-cycle strobe per counted basket (debug LED).

Behaviour:
- Reset: interface decided as one clock `clock`; reset `reset` is synchronous and active-low. Reset is sampled only on posedge clock while reset==0.
- Values under reset:
  - state=IDLE, score=0, final_score=0, time_left=GAME_SECS, game_active=0, game_over=0, basket=0.
  - Synchronisers, debounce counter and tick counter are cleared.
  - Debounced level = 0.
- Input conditioning:
  - start and in_switch each pass through a 2-flop synchroniser.
  - in_switch is then debounced. A counter runs while the synchronised level differs from the debounced level and clears when they match. When the counter reaches DEBOUNCE_CYC-1, the debounced level flips.
  - A debounced 0->1 edge is a shot event: one-cycle, at most one per accepted edge.
  - start_rise is the synchronised 0->1 edge of start.
- State machine IDLE, RUN, DONE:
  - IDLE: on start_rise go to RUN. Load time_left=GAME_SECS, clear score and the tick counter. Shot events are ignored.
  - RUN:
    - The tick counter increments each cycle. At CLK_HZ-1 it wraps to 0 and time_left decrements.
    - When time_left is 1 and a wrap occurs, time_left becomes 0, the state goes to DONE and game_over pulses. In the same cycle, final_score is set to the score value including any same-cycle shot.
    - start_rise in RUN is ignored.
  - DONE: time_left holds at 0 and score holds. On start_rise, act as IDLE->RUN (new round). final_score is retained until the next game_over.
- Scoring:
  - A shot event in RUN increments score by 1 and pulses basket.
  - score saturates at 2^SCORE_W-1; when saturated, basket still pulses.
  - A shot in the same cycle as the final wrap is counted.
  - Shots in IDLE or DONE are dropped, with no basket pulse.
- Latency:
  - Raw switch edge to basket/score update is 2 (sync) + DEBOUNCE_CYC + 1 cycles.
  - start edge to game_active=1 is 3 cycles after the start edge.
- Reset mid-round: return to IDLE next edge with all values above. No game_over is emitted.
- Width rules: time_left is 8-bit unsigned and never goes below 0. The tick counter is width $clog2(CLK_HZ).

Decomposition:
- Shared package hoop_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default CLK_HZ and GAME_SECS constants;
  - the SCORE_W default, shared with leaderboard.
- One natural sub-module: hoop_debounce (2-flop sync + hold counter + rising-edge strobe; parameter DEBOUNCE_CYC). It is instantiated once for in_switch. start uses only the synchroniser and edge detect inside the top.

Test Plan:
All scenarios use bench parameters CLK_HZ=10, GAME_SECS=3, DEBOUNCE_CYC=4.
1. Hold reset=0 for 2 cycles, release → score=0, time_left=3, game_active=0, game_over=0. Toggle in_switch 0/1 cleanly in IDLE → score stays 0, no basket.
2. Pulse start, then hold in_switch=1 for 10 cycles, low 10, high 10 → score=2, two basket strobes, each 7 cycles after its raw edge. time_left reads 3,2,1 at 10-cycle spacing.
3. Bounce in_switch 1,0,1,0 on alternate cycles, then hold 1 → exactly one basket. A glitch of 3 cycles → no basket.
4. Run a full round → game_over high exactly 1 cycle, 30 cycles after game_active rose. time_left=0, final_score=score, state DONE. Later shots are ignored.
5. Align a debounced shot edge to the final-wrap cycle → counted: final_score = prior score + 1.
6. Assert reset=0 mid-RUN (time_left=2, score=1) → next cycle state IDLE, score=0, time_left=3, no game_over. Force score to 255, then shoot → score stays 255 and basket pulses. start in DONE → new round, score=0.
